slv_i2c_reg_ctrl: RTL and testbench

- Register-file controller behind the I2C slave FSM.
- Decodes slave transactions into register writes and auto-incrementing register reads.
- Drives the slave's ACK and transmit-data inputs.
- Arbitrates the single register-file write port between the I2C side and a local host port; I2C has priority.

---
 rtl/slv_i2c_reg_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_slv_i2c_reg_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slv_i2c_reg_ctrl.sv
// -----------------------------------------------------------------------------
// slv_i2c_reg_ctrl
//
// Register-file controller that sits behind an I2C slave FSM. It turns slave
// transactions into register writes and auto-incrementing register reads. It
// drives the slave's ACK level and transmit byte. It also shares the single
// register-file write port with a local host port, and I2C has priority on
// that port.
//
// Ports
//   CLK, RST      : system clock, asynchronous active-high reset
//   I_ADDR_SLV    : 7-bit slave address decoded by the slave FSM
//   I_RW          : transaction direction, 1 = master reads
//   I_DATA_RD     : byte received from the master
//   I_DATA_VL     : strobe, byte received (write) or transmit byte consumed (read)
//   I_ADDR_REG    : register address byte sent by the master
//   I_BUSY        : slave transaction in progress
//   O_ACK         : ACK level to the slave (combinational), 1 = ACK
//   O_DATA_WR     : byte to transmit to the master
//   I_HST_*       : host request / write enable / address / write data
//   O_HST_GNT     : one-cycle grant, the host access happens this cycle
//   O_HST_RDATA   : host read data, O_HST_RVL marks it valid
//   O_IRQ         : pulse after an I2C write that stored at least one byte
//   O_ERR         : pulse after an out-of-range or read-only I2C write byte
// -----------------------------------------------------------------------------
module slv_i2c_reg_ctrl #(
    parameter int                 DATA_SZ  = 8,
    parameter int                 REG_NUM  = 16,
    parameter logic [DATA_SZ-2:0] SLV_ADDR = 7'h50,
    parameter logic [REG_NUM-1:0] RO_MASK  = 16'h0000,
    localparam int                PTR_SZ   = $clog2(REG_NUM)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DATA_SZ-2:0] I_ADDR_SLV,
    input  logic               I_RW,
    input  logic [DATA_SZ-1:0] I_DATA_RD,
    input  logic               I_DATA_VL,
    input  logic [DATA_SZ-1:0] I_ADDR_REG,
    input  logic               I_BUSY,
    output logic               O_ACK,
    output logic [DATA_SZ-1:0] O_DATA_WR,
    input  logic               I_HST_REQ,
    input  logic               I_HST_WE,
    input  logic [PTR_SZ-1:0]  I_HST_ADDR,
    input  logic [DATA_SZ-1:0] I_HST_WDATA,
    output logic               O_HST_GNT,
    output logic [DATA_SZ-1:0] O_HST_RDATA,
    output logic               O_HST_RVL,
    output logic               O_IRQ,
    output logic               O_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_FIRST,
        ST_WR,
        ST_RD
    } state_t;

    localparam logic [PTR_SZ-1:0] PTR_LAST = PTR_SZ'(REG_NUM - 1);

    state_t              state_q, state_d;
    logic                busy_q;
    logic [PTR_SZ-1:0]   ptr_q, ptr_d;
    logic [DATA_SZ-1:0]  regs_q [REG_NUM];
    logic [DATA_SZ-1:0]  regs_d [REG_NUM];
    logic [DATA_SZ-1:0]  data_wr_q, data_wr_d;
    logic [DATA_SZ-1:0]  hst_rdata_q, hst_rdata_d;
    logic                hst_rvl_q, hst_rvl_d;
    logic                irq_q, irq_d;
    logic                err_q, err_d;
    logic                stored_q, stored_d;

    logic                busy_rise, busy_fall;
    logic                addr_match;
    logic                reg_in_range;
    logic                hst_in_range;
    logic [PTR_SZ-1:0]   first_ptr, first_inc, ptr_inc;
    logic                first_ok;
    logic                in_write;
    logic                wr_strobe, rd_strobe;
    logic                i2c_store, i2c_drop;
    logic [PTR_SZ-1:0]   i2c_wr_addr;
    logic                write_end;
    logic                hst_gnt;

    // Decode of the current slave activity. The pointer wraps explicitly so
    // register counts that are not a power of two still wrap to zero.
    always_comb begin
        busy_rise    = I_BUSY & ~busy_q;
        busy_fall    = ~I_BUSY & busy_q;
        addr_match   = (I_ADDR_SLV == SLV_ADDR);
        reg_in_range = (32'(I_ADDR_REG) < REG_NUM);
        hst_in_range = (32'(I_HST_ADDR) < REG_NUM);
        first_ptr    = I_ADDR_REG[PTR_SZ-1:0];
        first_inc    = (first_ptr == PTR_LAST) ? '0 : first_ptr + PTR_SZ'(1);
        ptr_inc      = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_SZ'(1);
        first_ok     = reg_in_range & ~RO_MASK[first_ptr];
        in_write     = (state_q == ST_WR_FIRST) || (state_q == ST_WR);
        wr_strobe    = in_write & I_DATA_VL & addr_match;
        rd_strobe    = (state_q == ST_RD) & I_DATA_VL & addr_match;
        if (state_q == ST_WR_FIRST) begin
            i2c_store   = wr_strobe & first_ok;
            i2c_wr_addr = first_ptr;
        end else begin
            i2c_store   = wr_strobe & ~RO_MASK[ptr_q];
            i2c_wr_addr = ptr_q;
        end
        i2c_drop  = wr_strobe & ~i2c_store;
        write_end = in_write & (busy_fall | busy_rise);
        // The host only loses the write port to an I2C byte that is actually
        // stored; grant is forced low while reset is held.
        hst_gnt   = I_HST_REQ & ~i2c_store & ~RST;
    end

    // ACK is combinational so the slave sees it in the same cycle it asks.
    always_comb begin
        O_ACK = 1'b0;
        case (state_q)
            ST_WR_FIRST: O_ACK = addr_match & reg_in_range;
            ST_WR:       O_ACK = addr_match & ~RO_MASK[ptr_q];
            ST_RD:       O_ACK = addr_match;
            default:     O_ACK = 1'b0;
        endcase
    end

    // Next-state logic. A busy rise always restarts the transaction by
    // direction, which also covers a repeated start without passing IDLE.
    always_comb begin
        state_d = state_q;
        if (busy_rise) begin
            state_d = I_RW ? ST_RD : ST_WR_FIRST;
        end else if (busy_fall) begin
            state_d = ST_IDLE;
        end else if ((state_q == ST_WR_FIRST) && i2c_store) begin
            state_d = ST_WR;
        end
    end

    // Datapath: register file, pointer, transmit byte, host read port and
    // the IRQ/ERR pulses. All reads use the current register contents, so a
    // read in the same cycle as a write sees the old value.
    always_comb begin
        regs_d      = regs_q;
        ptr_d       = ptr_q;
        data_wr_d   = data_wr_q;
        hst_rdata_d = hst_rdata_q;
        hst_rvl_d   = 1'b0;
        err_d       = i2c_drop;
        irq_d       = write_end & (stored_q | i2c_store);
        stored_d    = write_end ? 1'b0 : (stored_q | i2c_store);

        if (i2c_store) begin
            regs_d[i2c_wr_addr] = I_DATA_RD;
        end else if (hst_gnt && I_HST_WE && hst_in_range) begin
            regs_d[I_HST_ADDR] = I_HST_WDATA;
        end

        if (wr_strobe) begin
            if (state_q == ST_WR_FIRST) begin
                if (first_ok) begin
                    ptr_d = first_inc;
                end
            end else begin
                ptr_d = ptr_inc;
            end
        end

        if (rd_strobe) begin
            ptr_d     = ptr_inc;
            data_wr_d = regs_q[ptr_inc];
        end

        if (busy_rise && I_RW && addr_match) begin
            data_wr_d = regs_q[ptr_q];
        end

        if (hst_gnt && !I_HST_WE) begin
            hst_rvl_d   = 1'b1;
            hst_rdata_d = hst_in_range ? regs_q[I_HST_ADDR] : '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            ptr_q       <= '0;
            data_wr_q   <= '0;
            hst_rdata_q <= '0;
            hst_rvl_q   <= 1'b0;
            irq_q       <= 1'b0;
            err_q       <= 1'b0;
            stored_q    <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= I_BUSY;
            ptr_q       <= ptr_d;
            data_wr_q   <= data_wr_d;
            hst_rdata_q <= hst_rdata_d;
            hst_rvl_q   <= hst_rvl_d;
            irq_q       <= irq_d;
            err_q       <= err_d;
            stored_q    <= stored_d;
            regs_q      <= regs_d;
        end
    end

    assign O_DATA_WR   = data_wr_q;
    assign O_HST_GNT   = hst_gnt;
    assign O_HST_RDATA = hst_rdata_q;
    assign O_HST_RVL   = hst_rvl_q;
    assign O_IRQ       = irq_q;
    assign O_ERR       = err_q;

endmodule

// File: tb/tb_slv_i2c_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_slv_i2c_reg_ctrl
//
// Self-checking bench for slv_i2c_reg_ctrl. Transactions are driven at byte
// level and compared against a transaction-level model: an array of register
// values plus a pointer, updated from the addressing rules of the controller.
// Register 2 is made read-only to exercise the read-only path.
// -----------------------------------------------------------------------------
module tb_slv_i2c_reg_ctrl;

    localparam logic [6:0]  DEV_ADDR = 7'h50;
    localparam logic [15:0] RO       = 16'h0004;

    logic       CLK = 1'b0;
    logic       RST;
    logic [6:0] I_ADDR_SLV;
    logic       I_RW;
    logic [7:0] I_DATA_RD;
    logic       I_DATA_VL;
    logic [7:0] I_ADDR_REG;
    logic       I_BUSY;
    logic       O_ACK;
    logic [7:0] O_DATA_WR;
    logic       I_HST_REQ;
    logic       I_HST_WE;
    logic [3:0] I_HST_ADDR;
    logic [7:0] I_HST_WDATA;
    logic       O_HST_GNT;
    logic [7:0] O_HST_RDATA;
    logic       O_HST_RVL;
    logic       O_IRQ;
    logic       O_ERR;

    int         checks = 0;
    int         fails  = 0;

    logic [7:0] mdl [16];
    int         mptr;
    logic [7:0] burst [8];

    slv_i2c_reg_ctrl #(
        .DATA_SZ (8),
        .REG_NUM (16),
        .SLV_ADDR(DEV_ADDR),
        .RO_MASK (RO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .I_ADDR_SLV (I_ADDR_SLV),
        .I_RW       (I_RW),
        .I_DATA_RD  (I_DATA_RD),
        .I_DATA_VL  (I_DATA_VL),
        .I_ADDR_REG (I_ADDR_REG),
        .I_BUSY     (I_BUSY),
        .O_ACK      (O_ACK),
        .O_DATA_WR  (O_DATA_WR),
        .I_HST_REQ  (I_HST_REQ),
        .I_HST_WE   (I_HST_WE),
        .I_HST_ADDR (I_HST_ADDR),
        .I_HST_WDATA(I_HST_WDATA),
        .O_HST_GNT  (O_HST_GNT),
        .O_HST_RDATA(O_HST_RDATA),
        .O_HST_RVL  (O_HST_RVL),
        .O_IRQ      (O_IRQ),
        .O_ERR      (O_ERR)
    );

    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic busy, input logic rw,
                                 input logic vl, input logic [7:0] data);
        I_BUSY    = busy;
        I_RW      = rw;
        I_DATA_VL = vl;
        I_DATA_RD = data;
    endtask

    // Master write: register address byte followed by n data bytes.
    task automatic i2cWrite(input logic [6:0] slv, input logic [7:0] reg_addr,
                            input int n);
        bit first  = 1'b1;
        bit stored = 1'b0;
        bit match;
        bit legal;
        bit ack_exp;
        bit err_exp;
        match      = (slv == DEV_ADDR);
        I_ADDR_SLV = slv;
        I_ADDR_REG = reg_addr;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, burst[i]);
            #1;
            if (!match) begin
                ack_exp = 1'b0;
                err_exp = 1'b0;
            end else if (first) begin
                ack_exp = (reg_addr < 8'd16);
                legal   = ack_exp && !RO[reg_addr[3:0]];
                err_exp = !legal;
                if (legal) begin
                    mdl[reg_addr[3:0]] = burst[i];
                    mptr   = (int'(reg_addr) + 1) % 16;
                    first  = 1'b0;
                    stored = 1'b1;
                end
            end else begin
                legal   = !RO[mptr];
                ack_exp = legal;
                err_exp = !legal;
                if (legal) begin
                    mdl[mptr] = burst[i];
                    stored    = 1'b1;
                end
                mptr = (mptr + 1) % 16;
            end
            checkOutput("wrAck", O_ACK, ack_exp);
            step();
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput("wrErr", O_ERR, err_exp);
            step();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        checkOutput("wrIrq", O_IRQ, stored);
        step();
        checkOutput("wrIrqClr", O_IRQ, 1'b0);
    endtask

    // Master read from the current pointer, with n transmit-byte strobes.
    task automatic i2cRead(input int n);
        I_ADDR_SLV = DEV_ADDR;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        step();
        checkOutput("rdEntry", O_DATA_WR, mdl[mptr]);
        checkOutput("rdAck", O_ACK, 1'b1);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
            step();
            applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
            mptr = (mptr + 1) % 16;
            checkOutput("rdData", O_DATA_WR, mdl[mptr]);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        checkOutput("rdNoIrq", O_IRQ, 1'b0);
        step();
    endtask

    // Host access with no I2C activity: granted immediately.
    task automatic hostAccess(input logic we, input logic [3:0] addr,
                              input logic [7:0] wdata);
        I_HST_REQ   = 1'b1;
        I_HST_WE    = we;
        I_HST_ADDR  = addr;
        I_HST_WDATA = wdata;
        #1;
        checkOutput("hstGnt", O_HST_GNT, 1'b1);
        step();
        I_HST_REQ = 1'b0;
        I_HST_WE  = 1'b0;
        if (we) begin
            mdl[addr] = wdata;
            checkOutput("hstWrNoRvl", O_HST_RVL, 1'b0);
        end else begin
            checkOutput("hstRvl", O_HST_RVL, 1'b1);
            checkOutput("hstRdata", O_HST_RDATA, mdl[addr]);
        end
        step();
        checkOutput("hstRvlClr", O_HST_RVL, 1'b0);
    endtask

    task automatic checkAllOutputsZero(input string tag);
        checkOutput({tag, "DataWr"}, O_DATA_WR, 8'h00);
        checkOutput({tag, "Ack"}, O_ACK, 1'b0);
        checkOutput({tag, "Gnt"}, O_HST_GNT, 1'b0);
        checkOutput({tag, "Rdata"}, O_HST_RDATA, 8'h00);
        checkOutput({tag, "Rvl"}, O_HST_RVL, 1'b0);
        checkOutput({tag, "Irq"}, O_IRQ, 1'b0);
        checkOutput({tag, "Err"}, O_ERR, 1'b0);
    endtask

    initial begin
        RST         = 1'b1;
        I_ADDR_SLV  = DEV_ADDR;
        I_ADDR_REG  = 8'h00;
        I_HST_REQ   = 1'b0;
        I_HST_WE    = 1'b0;
        I_HST_ADDR  = 4'h0;
        I_HST_WDATA = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mptr = 0;
        step();
        step();
        checkAllOutputsZero("rst");
        RST = 1'b0;
        step();

        $display("[TB] directed write burst");
        burst[0] = 8'hA1; burst[1] = 8'hA2; burst[2] = 8'hA3;
        i2cWrite(DEV_ADDR, 8'd3, 3);
        checkOutput("burstPtr", mptr, 6);

        $display("[TB] directed read with wrap");
        burst[0] = 8'h3C;
        i2cWrite(DEV_ADDR, 8'd13, 1);
        hostAccess(1'b1, 4'd14, 8'hE4);
        hostAccess(1'b1, 4'd15, 8'hF5);
        hostAccess(1'b1, 4'd0, 8'h0A);
        hostAccess(1'b1, 4'd1, 8'h1B);
        i2cRead(3);

        $display("[TB] illegal accesses");
        burst[0] = 8'h77;
        i2cWrite(DEV_ADDR, 8'd20, 1);
        burst[0] = 8'h66;
        i2cWrite(DEV_ADDR, 8'd2, 1);
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        i2cWrite(DEV_ADDR, 8'd1, 3);
        burst[0] = 8'h5A;
        i2cWrite(7'h51, 8'd9, 1);

        $display("[TB] host/I2C write collision");
        I_ADDR_SLV = DEV_ADDR;
        I_ADDR_REG = 8'd8;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        I_HST_REQ   = 1'b1;
        I_HST_WE    = 1'b1;
        I_HST_ADDR  = 4'd7;
        I_HST_WDATA = 8'h55;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h99);
        #1;
        checkOutput("colGntBlocked", O_HST_GNT, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        checkOutput("colGntLate", O_HST_GNT, 1'b1);
        step();
        I_HST_REQ = 1'b0;
        I_HST_WE  = 1'b0;
        mdl[8] = 8'h99;
        mdl[7] = 8'h55;
        mptr   = 9;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        checkOutput("colIrq", O_IRQ, 1'b1);
        step();
        hostAccess(1'b0, 4'd7, 8'h00);
        hostAccess(1'b0, 4'd8, 8'h00);
        hostAccess(1'b0, 4'd4, 8'h00);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    for (int i = 0; i < 8; i++) burst[i] = 8'($urandom);
                    i2cWrite(($urandom_range(0, 9) == 0) ? 7'h51 : DEV_ADDR,
                             8'($urandom_range(0, 19)), $urandom_range(1, 4));
                end
                1: i2cRead($urandom_range(0, 5));
                default: hostAccess(1'($urandom_range(0, 1)),
                                    4'($urandom_range(0, 15)), 8'($urandom));
            endcase
        end

        $display("[TB] reset in the middle of a write burst");
        I_ADDR_SLV = DEV_ADDR;
        I_ADDR_REG = 8'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hC1);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hC2);
        #2;
        RST = 1'b1;
        #1;
        checkAllOutputsZero("midRst");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mptr = 0;
        step();
        step();
        RST = 1'b0;
        step();
        checkOutput("postRstIrq", O_IRQ, 1'b0);
        I_ADDR_SLV = DEV_ADDR;
        #1;
        checkOutput("postRstIdleAck", O_ACK, 1'b0);
        step();
        checkOutput("postRstIrq2", O_IRQ, 1'b0);
        i2cRead(1);

        $display("[TB] final register file sweep");
        for (int i = 0; i < 16; i++) begin
            hostAccess(1'b0, 4'(i), 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
